// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IM address generation and the IF/ID pipeline register.
// Optional macro IF_ADEL_EN adds a registered fetch address-error flag (id_exc_adel).
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             redirect,
   input  logic [31:0]      redirect_target,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc8,
   output logic             id_valid
`ifdef IF_ADEL_EN
   ,
   output logic             id_exc_adel
`endif
);

   logic [31:0] r_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_pc8;
   logic        r_id_valid;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_plus8;
   logic [31:0] w_fetch_word;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_pc_plus8 = r_pc + 32'd8;

   // IM address depends only on the pc register; offset wraps within IM_AW bits
   assign im_addr = IM_AW'((r_pc - PC_RESET) >> 2);

`ifdef IF_ADEL_EN
   localparam logic [32:0] IM_END = 33'(PC_RESET) + (33'd1 << (IM_AW + 2));

   logic r_id_exc_adel;
   logic w_adel;

   assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) ||
                   ({1'b0, r_pc} >= IM_END);
   // A faulting fetch is delivered as a valid nop carrying the exception flag
   assign w_fetch_word = w_adel ? 32'd0 : im_rdata;
   assign id_exc_adel  = r_id_exc_adel;
`else
   assign w_fetch_word = im_rdata;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc       <= PC_RESET;
         r_id_instr <= 32'd0;
         r_id_pc    <= 32'd0;
         r_id_pc8   <= 32'd0;
         r_id_valid <= 1'b0;
`ifdef IF_ADEL_EN
         r_id_exc_adel <= 1'b0;
`endif
      end else if (!stall) begin
         // Redirect does not squash the delay-slot word captured this cycle
         r_pc <= redirect ? redirect_target : w_pc_plus4;
         if (flush) begin
            r_id_instr <= 32'd0;
            r_id_valid <= 1'b0;
`ifdef IF_ADEL_EN
            r_id_exc_adel <= 1'b0;
`endif
         end else begin
            r_id_instr <= w_fetch_word;
            r_id_pc    <= r_pc;
            r_id_pc8   <= w_pc_plus8;
            r_id_valid <= 1'b1;
`ifdef IF_ADEL_EN
            r_id_exc_adel <= w_adel;
`endif
         end
      end
   end

   assign pc       = r_pc;
   assign id_instr = r_id_instr;
   assign id_pc    = r_id_pc;
   assign id_pc8   = r_id_pc8;
   assign id_valid = r_id_valid;

endmodule
